// File: rtl/op_mux_stream_if.sv
// Operand/command/result stream bundle for op_mux_stream.
// The master drives operands, commands and out_ready; the slave is the mux.
interface op_mux_stream_if #(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned OP_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH = 8
);
  localparam int unsigned SEL_WIDTH = $clog2(NUM_IN);

  logic [NUM_IN*OP_WIDTH-1:0] in_op;
  logic [NUM_IN-1:0]          in_valid;
  logic [NUM_IN-1:0]          in_ready;
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [1:0]                 cmd_mode;
  logic [SEL_WIDTH-1:0]       cmd_sel;
  logic [CNT_WIDTH-1:0]       cmd_count;
  logic [OP_WIDTH-1:0]        out_op;
  logic                       out_valid;
  logic                       out_ready;
  logic                       busy;

  modport master (
    output in_op, in_valid, cmd_valid, cmd_mode, cmd_sel, cmd_count, out_ready,
    input  in_ready, cmd_ready, out_op, out_valid, busy
  );

  modport slave (
    input  in_op, in_valid, cmd_valid, cmd_mode, cmd_sel, cmd_count, out_ready,
    output in_ready, cmd_ready, out_op, out_valid, busy
  );
endinterface

// File: rtl/op_mux_stream.sv
// Command-driven operand mux: each command emits count+1 beats of ZERO, a selected
// lane's operands, or the last emitted value, into a single registered output slot.
module op_mux_stream #(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned OP_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  op_mux_stream_if.slave bus
);
  localparam int unsigned SEL_WIDTH = $clog2(NUM_IN);

  typedef enum logic {StIdle, StRun} state_e;

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [OP_WIDTH-1:0]  out_op_q, out_op_d;
  logic [OP_WIDTH-1:0]  last_q, last_d;
  logic                 out_valid_q, out_valid_d;

  logic                 cmd_ready;
  logic                 slot_free;
  logic                 sel_hit;
  logic                 lane_valid;
  logic [OP_WIDTH-1:0]  lane_op;
  logic                 use_lane;
  logic                 use_hold;
  logic                 src_avail;
  logic [OP_WIDTH-1:0]  src_op;
  logic                 beat;
  logic [NUM_IN-1:0]    in_ready;

  // A selector beyond the last lane matches nothing, so SELECT degrades to ZERO.
  always_comb begin
    sel_hit    = 1'b0;
    lane_valid = 1'b0;
    lane_op    = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (sel_q == SEL_WIDTH'(i)) begin
        sel_hit    = 1'b1;
        lane_valid = bus.in_valid[i];
        lane_op    = bus.in_op[i*OP_WIDTH +: OP_WIDTH];
      end
    end
  end

  // Modes 1 and 3 both select a lane; mode 2 replays the last emitted value.
  assign use_lane  = mode_q[0] && sel_hit;
  assign use_hold  = (mode_q == 2'd2);
  assign src_avail = use_lane ? lane_valid : 1'b1;
  assign src_op    = use_lane ? lane_op : (use_hold ? last_q : '0);
  assign slot_free = !out_valid_q || bus.out_ready;
  assign beat      = (state_q == StRun) && slot_free && src_avail;
  assign cmd_ready = (state_q == StIdle) && !rst;

  always_comb begin
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      in_ready[i] = (state_q == StRun) && use_lane && (sel_q == SEL_WIDTH'(i)) && slot_free;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    sel_d       = sel_q;
    remaining_d = remaining_q;
    out_op_d    = out_op_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready) begin
          mode_d      = bus.cmd_mode;
          sel_d       = bus.cmd_sel;
          remaining_d = bus.cmd_count;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (beat) begin
          if (remaining_q == '0) begin
            state_d = StIdle;
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (beat) begin
      out_op_d    = src_op;
      out_valid_d = 1'b1;
      last_d      = src_op;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      sel_q       <= '0;
      remaining_q <= '0;
      out_op_q    <= '0;
      out_valid_q <= 1'b0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      remaining_q <= remaining_d;
      out_op_q    <= out_op_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.cmd_ready = cmd_ready;
  assign bus.out_op    = out_op_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == StRun) || out_valid_q;
endmodule

// File: tb/tb_op_mux_stream.sv
// Bench for op_mux_stream: cycle vector table, directed reset/boundary sequences,
// a NUM_IN=3 instance, and random commands scored against an expected-beat queue.
module tb_op_mux_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  op_mux_stream_if #(.NUM_IN(4), .OP_WIDTH(32), .CNT_WIDTH(8)) b4 ();
  op_mux_stream_if #(.NUM_IN(3), .OP_WIDTH(8),  .CNT_WIDTH(2)) b3 ();

  op_mux_stream #(.NUM_IN(4), .OP_WIDTH(32), .CNT_WIDTH(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.slave)
  );

  op_mux_stream #(.NUM_IN(3), .OP_WIDTH(8), .CNT_WIDTH(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        cv;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [7:0]  cnt;
    logic [3:0]  iv;
    logic [31:0] lv;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_op;
    logic [3:0]  e_ir;
    logic        e_cr;
    logic        e_busy;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(input int cv, input int mode, input int sel, input int cnt,
                              input int iv, input int lv, input int ordy, input int e_ov,
                              input int e_op, input int e_ir, input int e_cr, input int e_busy);
    vec_t v;
    v.cv = 1'(cv); v.mode = 2'(mode); v.sel = 2'(sel); v.cnt = 8'(cnt);
    v.iv = 4'(iv); v.lv = 32'(lv); v.ordy = 1'(ordy); v.e_ov = 1'(e_ov);
    v.e_op = 32'(e_op); v.e_ir = 4'(e_ir); v.e_cr = 1'(e_cr); v.e_busy = 1'(e_busy);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Lane i carries base + i*0x100 so a wrong-lane pick shows up in the value.
  task automatic drive_lanes4(input logic [31:0] base);
    for (int l = 0; l < 4; l++) b4.in_op[l*32 +: 32] = base + 32'(l * 'h100);
  endtask

  task automatic idle_inputs();
    b4.cmd_valid = 1'b0; b4.cmd_mode = '0; b4.cmd_sel = '0; b4.cmd_count = '0;
    b4.in_valid = '0; b4.in_op = '0; b4.out_ready = 1'b1;
    b3.cmd_valid = 1'b0; b3.cmd_mode = '0; b3.cmd_sel = '0; b3.cmd_count = '0;
    b3.in_valid = '0; b3.in_op = '0; b3.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("reset cmd_ready", 32'(b4.cmd_ready), 0);
    check("reset in_ready", 32'(b4.in_ready), 0);
    check("reset busy", 32'(b4.busy), 0);
    check("reset out_valid", 32'(b4.out_valid), 0);
    check("reset out_op", b4.out_op, 0);
    check("reset cmd_ready n3", 32'(b3.cmd_ready), 0);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic run3(input int m, input int s, input int k, output int beats,
                      output logic [7:0] orv, output logic [2:0] irv);
    beats = 0; orv = '0; irv = '0;
    @(negedge clk);
    b3.cmd_valid = 1'b1; b3.cmd_mode = 2'(m); b3.cmd_sel = 2'(s); b3.cmd_count = 2'(k);
    b3.in_valid = 3'b111; b3.in_op = 24'h5A3CC3; b3.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      b3.cmd_valid = 1'b0;
      #1;
      if (b3.out_valid) begin
        beats++;
        orv = orv | b3.out_op;
      end
      irv = irv | b3.in_ready;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, s, k, idx, cyc, beats, first, last, bad;
    bit issued, is_sel;
    logic [31:0] v, last_model;
    logic [3:0]  mask;
    logic [7:0]  orv;
    logic [2:0]  irv;
    logic [31:0] exp_q[$];
    logic [31:0] src_q[$];

    //           cv m s c  iv      lv    rdy  ov op      ir      cr busy
    vecs[0]  = mk(1, 1, 2, 3, 'b0000, 'h0,  1,   0, 'h0,   'b0000, 1, 0);
    vecs[1]  = mk(0, 0, 0, 0, 'b0100, 'hA,  1,   0, 'h0,   'b0100, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 'b0100, 'hB,  1,   1, 'h20A, 'b0100, 0, 1);
    vecs[3]  = mk(0, 0, 0, 0, 'b0100, 'hC,  1,   1, 'h20B, 'b0100, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 'b0100, 'hD,  1,   1, 'h20C, 'b0100, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 'b0000, 'h0,  1,   1, 'h20D, 'b0000, 1, 1);
    vecs[6]  = mk(1, 1, 1, 0, 'b0010, 'h55, 1,   0, 'h0,   'b0000, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 'b0010, 'h55, 1,   0, 'h0,   'b0010, 0, 1);
    vecs[8]  = mk(1, 2, 0, 2, 'b0000, 'h0,  1,   1, 'h155, 'b0000, 1, 1);
    vecs[9]  = mk(0, 0, 0, 0, 'b0000, 'h0,  1,   0, 'h0,   'b0000, 0, 1);
    vecs[10] = mk(0, 0, 0, 0, 'b0000, 'h0,  1,   1, 'h155, 'b0000, 0, 1);
    vecs[11] = mk(0, 0, 0, 0, 'b0000, 'h0,  1,   1, 'h155, 'b0000, 0, 1);
    vecs[12] = mk(1, 0, 0, 0, 'b0000, 'h0,  1,   1, 'h155, 'b0000, 1, 1);
    vecs[13] = mk(0, 0, 0, 0, 'b0000, 'h0,  1,   0, 'h0,   'b0000, 0, 1);
    vecs[14] = mk(1, 2, 0, 0, 'b0000, 'h0,  1,   1, 'h0,   'b0000, 1, 1);
    vecs[15] = mk(0, 0, 0, 0, 'b0000, 'h0,  1,   0, 'h0,   'b0000, 0, 1);
    vecs[16] = mk(0, 0, 0, 0, 'b0000, 'h0,  1,   1, 'h0,   'b0000, 1, 1);
    vecs[17] = mk(1, 1, 0, 3, 'b0001, 'h31, 1,   0, 'h0,   'b0000, 1, 0);
    vecs[18] = mk(0, 0, 0, 0, 'b0001, 'h31, 1,   0, 'h0,   'b0001, 0, 1);
    vecs[19] = mk(0, 0, 0, 0, 'b0001, 'h32, 0,   1, 'h31,  'b0000, 0, 1);
    vecs[20] = mk(0, 0, 0, 0, 'b0001, 'h32, 0,   1, 'h31,  'b0000, 0, 1);
    vecs[21] = mk(0, 0, 0, 0, 'b0001, 'h32, 0,   1, 'h31,  'b0000, 0, 1);
    vecs[22] = mk(0, 0, 0, 0, 'b0001, 'h32, 1,   1, 'h31,  'b0001, 0, 1);
    vecs[23] = mk(0, 0, 0, 0, 'b0001, 'h33, 1,   1, 'h32,  'b0001, 0, 1);
    vecs[24] = mk(0, 0, 0, 0, 'b0000, 'h34, 1,   1, 'h33,  'b0001, 0, 1);
    vecs[25] = mk(0, 0, 0, 0, 'b0000, 'h34, 1,   0, 'h0,   'b0001, 0, 1);
    vecs[26] = mk(0, 0, 0, 0, 'b0000, 'h34, 1,   0, 'h0,   'b0001, 0, 1);
    vecs[27] = mk(0, 0, 0, 0, 'b0001, 'h34, 1,   0, 'h0,   'b0001, 0, 1);
    vecs[28] = mk(0, 0, 0, 0, 'b0000, 'h0,  1,   1, 'h34,  'b0000, 1, 1);
    vecs[29] = mk(0, 0, 0, 0, 'b0000, 'h0,  1,   0, 'h0,   'b0000, 1, 0);

    do_reset();

    // Row 0 is offered before the first edge after reset release.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      b4.cmd_valid = vecs[i].cv; b4.cmd_mode = vecs[i].mode;
      b4.cmd_sel = vecs[i].sel; b4.cmd_count = vecs[i].cnt;
      b4.in_valid = vecs[i].iv; b4.out_ready = vecs[i].ordy;
      drive_lanes4(vecs[i].lv);
      #1;
      check($sformatf("vec%0d out_valid", i), 32'(b4.out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov) check($sformatf("vec%0d out_op", i), b4.out_op, vecs[i].e_op);
      check($sformatf("vec%0d in_ready", i), 32'(b4.in_ready), 32'(vecs[i].e_ir));
      check($sformatf("vec%0d cmd_ready", i), 32'(b4.cmd_ready), 32'(vecs[i].e_cr));
      check($sformatf("vec%0d busy", i), 32'(b4.busy), 32'(vecs[i].e_busy));
    end

    // Reset in the middle of a SELECT run with a beat waiting in the output slot.
    @(negedge clk);
    b4.cmd_valid = 1'b1; b4.cmd_mode = 2'd1; b4.cmd_sel = 2'd3; b4.cmd_count = 8'd5;
    drive_lanes4(32'h77); b4.in_valid = 4'b1000; b4.out_ready = 1'b1;
    @(negedge clk);
    b4.cmd_valid = 1'b0;
    @(negedge clk);
    #1;
    check("abort pre out_valid", 32'(b4.out_valid), 1);
    rst = 1'b1;
    #1;
    check("abort out_valid", 32'(b4.out_valid), 0);
    check("abort out_op", b4.out_op, 0);
    check("abort cmd_ready", 32'(b4.cmd_ready), 0);
    check("abort in_ready", 32'(b4.in_ready), 0);
    check("abort busy", 32'(b4.busy), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post-abort out_valid", 32'(b4.out_valid), 0);
      check("post-abort cmd_ready", 32'(b4.cmd_ready), 1);
      check("post-abort busy", 32'(b4.busy), 0);
    end
    @(negedge clk);
    b4.cmd_valid = 1'b1; b4.cmd_mode = 2'd1; b4.cmd_sel = 2'd3; b4.cmd_count = 8'd1;
    drive_lanes4(32'h78);
    @(negedge clk);
    b4.cmd_valid = 1'b0;
    #1;
    check("fresh c1 out_valid", 32'(b4.out_valid), 0);
    check("fresh c1 cmd_ready", 32'(b4.cmd_ready), 0);
    @(negedge clk); #1;
    check("fresh c2 out_valid", 32'(b4.out_valid), 1);
    check("fresh c2 out_op", b4.out_op, 32'h378);
    check("fresh c2 cmd_ready", 32'(b4.cmd_ready), 0);
    @(negedge clk); #1;
    check("fresh c3 out_valid", 32'(b4.out_valid), 1);
    check("fresh c3 out_op", b4.out_op, 32'h378);
    check("fresh c3 cmd_ready", 32'(b4.cmd_ready), 1);
    @(negedge clk); #1;
    check("fresh c4 out_valid", 32'(b4.out_valid), 0);

    // Maximum count: 256 HOLD beats of the last value, back to back.
    @(negedge clk);
    b4.cmd_valid = 1'b1; b4.cmd_mode = 2'd2; b4.cmd_count = 8'd255; b4.in_valid = '0;
    @(negedge clk);
    b4.cmd_valid = 1'b0;
    beats = 0; first = -1; last = -1; bad = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      #1;
      if (b4.out_valid) begin
        if (first < 0) first = c;
        last = c;
        beats++;
        if (b4.out_op !== 32'h378) bad++;
      end
    end
    check("maxcnt beats", 32'(beats), 256);
    check("maxcnt span", 32'(last - first), 255);
    check("maxcnt values", 32'(bad), 0);
    check("maxcnt cmd_ready", 32'(b4.cmd_ready), 1);

    // NUM_IN=3 instance: out-of-range select, full 2-bit count, mode 3.
    run3(1, 3, 1, beats, orv, irv);
    check("n3 sel3 beats", 32'(beats), 2);
    check("n3 sel3 data", 32'(orv), 0);
    check("n3 sel3 in_ready", 32'(irv), 0);
    run3(1, 2, 3, beats, orv, irv);
    check("n3 sel2 beats", 32'(beats), 4);
    check("n3 sel2 data", 32'(orv), 32'h5A);
    check("n3 sel2 in_ready", 32'(irv), 32'b100);
    run3(3, 1, 0, beats, orv, irv);
    check("n3 mode3 beats", 32'(beats), 1);
    check("n3 mode3 data", 32'(orv), 32'h3C);
    check("n3 mode3 in_ready", 32'(irv), 32'b010);

    // Random commands; expected beats queued per command from the mode rules.
    do_reset();
    last_model = '0;
    for (int c = 0; c < 40; c++) begin
      m = $urandom_range(0, 3);
      s = $urandom_range(0, 3);
      k = $urandom_range(0, 7);
      is_sel = (m == 1) || (m == 3);
      src_q.delete();
      for (int j = 0; j <= k; j++) begin
        if (is_sel) begin
          v = $urandom;
          src_q.push_back(v);
        end else if (m == 2) begin
          v = last_model;
        end else begin
          v = '0;
        end
        exp_q.push_back(v);
        last_model = v;
      end
      mask = is_sel ? 4'(1 << s) : 4'b0000;
      idx = 0; cyc = 0; issued = 1'b0;
      while ((!issued || exp_q.size() != 0) && cyc < 300) begin
        @(negedge clk);
        b4.cmd_valid = !issued; b4.cmd_mode = 2'(m); b4.cmd_sel = 2'(s);
        b4.cmd_count = 8'(k);
        b4.out_ready = ($urandom_range(0, 3) != 0);
        for (int l = 0; l < 4; l++) begin
          b4.in_op[l*32 +: 32] = $urandom;
          b4.in_valid[l] = 1'($urandom_range(0, 1));
        end
        if (is_sel) begin
          b4.in_valid[s] = (idx < src_q.size()) && ($urandom_range(0, 3) != 0);
          if (idx < src_q.size()) b4.in_op[s*32 +: 32] = src_q[idx];
        end
        #1;
        check("rand in_ready lane", 32'(b4.in_ready & ~mask), 0);
        if (b4.in_ready != '0) check("rand in_ready slot", 32'(!b4.out_valid || b4.out_ready), 1);
        if (b4.out_valid && b4.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL rand extra beat: got 0x%0h, expected no beat", b4.out_op);
          end else begin
            check("rand beat", b4.out_op, exp_q.pop_front());
          end
        end
        if (b4.cmd_valid && b4.cmd_ready) issued = 1'b1;
        if (is_sel && b4.in_valid[s] && b4.in_ready[s]) idx++;
        cyc++;
      end
      if (cyc >= 300) begin
        n_cmp++; n_fail++;
        $display("FAIL rand timeout cmd %0d: got %0d beats pending, expected 0", c, exp_q.size());
        exp_q.delete();
        do_reset();
        last_model = '0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
